cic_decimator_var: RTL

- Runtime-rate CIC decimator with ready/valid streaming on both sides; the decimating counterpart of the team's CIC interpolator.
- Integrators run at the input (high) rate. Combs run once per R accepted samples.
- A runtime right-shift normalises gain, followed by optional rounding and saturation to OUT_WIDTH.
- Sits between a high-rate source (ADC or interpolator chain) and low-rate baseband processing.

---
 rtl/cic_pkg.sv | 52 +++++
 rtl/cic_decimator_var_quant.sv | 25 ++
 rtl/cic_decimator_var.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared CIC helpers: bit growth, rate clamping, round/saturate.
// Used by the decimator and the interpolator.
package cic_pkg;

  localparam int QW = 128;
  typedef logic signed [QW-1:0] qword_t;

  function automatic int cic_growth(
    input int stages,
    input int r,
    input int m
  );
    return stages * $clog2(r * m);
  endfunction

  function automatic int unsigned clamp_rate(
    input int unsigned rate,
    input int unsigned r_max
  );
    if (rate == 0) return 1;
    if (rate > r_max) return r_max;
    return rate;
  endfunction

  // Round-half-up then arithmetic shift; the wide word cannot overflow.
  function automatic qword_t round_shift(
    input qword_t x,
    input int unsigned sh,
    input bit use_round
  );
    qword_t b;
    b = x;
    if (use_round && sh > 0)
      b = b + (qword_t'(1) <<< (sh - 1));
    return b >>> sh;
  endfunction

  function automatic qword_t saturate(
    input qword_t x,
    input int unsigned w,
    input bit use_sat
  );
    qword_t hi, lo;
    hi = (qword_t'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (!use_sat) return x;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/cic_decimator_var_quant.sv
// Output quantizer: runtime shift, optional rounding and saturation.
module cic_out_quantizer
  import cic_pkg::*;
#(
  parameter int FULL_WIDTH = 34,
  parameter int OUT_WIDTH  = 24,
  parameter int USE_ROUND  = 1,
  parameter int USE_SAT    = 1,
  parameter int SW         = 6
) (
  input  logic signed [FULL_WIDTH-1:0] in_data,
  input  logic        [SW-1:0]         shift,
  output logic signed [OUT_WIDTH-1:0]  out_data
);

  qword_t wide;

  always_comb begin
    wide = qword_t'(in_data);
    out_data = OUT_WIDTH'(saturate(
      round_shift(wide, 32'(shift), USE_ROUND != 0),
      OUT_WIDTH, USE_SAT != 0));
  end

endmodule

// File: rtl/cic_decimator_var.sv
// Runtime-rate CIC decimator with ready/valid on both sides.
// Optional synchronous flush port: define CIC_DEC_FLUSH_EN.
module cic_decimator_var
  import cic_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int R_MAX     = 64,
  parameter int M         = 1,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 24,
  parameter int USE_ROUND = 1,
  parameter int USE_SAT   = 1,
  localparam int FULL_WIDTH =
    IN_WIDTH + cic_growth(STAGES, R_MAX, M),
  localparam int RW = $clog2(R_MAX + 1),
  localparam int SW = $clog2(FULL_WIDTH)
) (
  input  logic                        in_clock,
  input  logic                        in_reset_n,
  input  logic        [RW-1:0]        cfg_rate,
  input  logic        [SW-1:0]        cfg_shift,
`ifdef CIC_DEC_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  if (STAGES < 1 || R_MAX < 1 || !(M == 1 || M == 2) ||
      IN_WIDTH < 1 || OUT_WIDTH < 2 ||
      OUT_WIDTH > FULL_WIDTH) begin : g_bad_param
    $error("cic_decimator_var: invalid parameters");
  end

  logic signed [FULL_WIDTH-1:0] integ [STAGES];
  logic signed [FULL_WIDTH-1:0] dly [STAGES][M];
  logic signed [FULL_WIDTH-1:0] comb_in [STAGES];
  logic signed [FULL_WIDTH-1:0] comb_out [STAGES];
  logic signed [FULL_WIDTH-1:0] in_ext;
  logic signed [FULL_WIDTH-1:0] last_nxt;
  logic signed [OUT_WIDTH-1:0]  q_data;
  logic [RW-1:0] phase, r_lat, r_cur;
  logic [SW-1:0] shift_lat, shift_cur;
  logic flush_i, accept, last;

`ifdef CIC_DEC_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign in_ready = !(out_valid && !out_ready) && !flush_i;
  assign accept   = in_valid && in_ready;
  assign in_ext   = FULL_WIDTH'(in_data);

  // Last integrator value after this accept's update.
  if (STAGES == 1) begin : g_one
    assign last_nxt = integ[0] + in_ext;
  end else begin : g_many
    assign last_nxt = integ[STAGES-1] + integ[STAGES-2];
  end

  always_comb begin
    r_cur     = r_lat;
    shift_cur = shift_lat;
    // First sample of a block uses the config being latched now.
    if (phase == '0) begin
      r_cur     = RW'(clamp_rate(32'(cfg_rate), R_MAX));
      shift_cur = cfg_shift;
    end
    last = (phase == r_cur - RW'(1));
    comb_in[0]  = last_nxt;
    comb_out[0] = last_nxt - dly[0][M-1];
    for (int i = 1; i < STAGES; i++) begin
      comb_in[i]  = comb_out[i-1];
      comb_out[i] = comb_out[i-1] - dly[i][M-1];
    end
  end

  cic_out_quantizer #(
    .FULL_WIDTH(FULL_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .USE_ROUND (USE_ROUND),
    .USE_SAT   (USE_SAT),
    .SW        (SW)
  ) u_quant (
    .in_data (comb_out[STAGES-1]),
    .shift   (shift_cur),
    .out_data(q_data)
  );

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        integ[i] <= '0;
        for (int j = 0; j < M; j++) dly[i][j] <= '0;
      end
      phase     <= '0;
      r_lat     <= '0;
      shift_lat <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < STAGES; i++) begin
        integ[i] <= '0;
        for (int j = 0; j < M; j++) dly[i][j] <= '0;
      end
      phase <= '0;
    end else if (accept) begin
      integ[0] <= integ[0] + in_ext;
      for (int i = 1; i < STAGES; i++)
        integ[i] <= integ[i] + integ[i-1];
      if (phase == '0) begin
        r_lat     <= r_cur;
        shift_lat <= shift_cur;
      end
      phase <= last ? '0 : phase + RW'(1);
      if (last) begin
        for (int i = 0; i < STAGES; i++) begin
          dly[i][0] <= comb_in[i];
          for (int j = 1; j < M; j++) dly[i][j] <= dly[i][j-1];
        end
      end
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (accept && last) begin
      out_valid <= 1'b1;
      out_data  <= q_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
